// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit for the execute stage.
// Multiplies use an iterative shift-add. Divides use an iterative restoring
// divide. Both retire one bit per cycle on magnitudes, and the result sign
// is restored when the last bit is written.
// Boundary divides (divide by zero, signed overflow) finish in one cycle.
// Optional feature macro: MULDIV_FAST_MUL_EN. When defined, all multiplies
// use a single-cycle XLEN x XLEN multiplier and finish in one cycle.
//
// state  | meaning
// IDLE   | waiting for start, busy=0
// CALC   | iterating one bit per cycle, counter counts XLEN-1 down to 0
// DONE   | one-cycle done pulse; start here is accepted on the closing edge
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_is_div;
  logic            r_mulh;
  logic            r_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_res;

  // Operand decode at the accept edge.
  logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_div0, w_ovf, w_fast, w_accept;
  logic [XLEN-1:0] w_fast_res;

  // For divides, op[0] marks the unsigned forms. For multiplies, only MULHU
  // treats op1 as unsigned, and MULHSU/MULHU treat op2 as unsigned.
  assign w_a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
  assign w_b_signed = op[2] ? ~op[0] : ~op[1];
  assign w_a_neg    = w_a_signed & op1[XLEN-1];
  assign w_b_neg    = w_b_signed & op2[XLEN-1];
  assign w_a_mag    = w_a_neg ? -op1 : op1;
  assign w_b_mag    = w_b_neg ? -op2 : op2;

  assign w_div0 = op[2] & (op2 == '0);
  assign w_ovf  = op[2] & ~op[0] & (op1 == MIN_NEG) & (op2 == '1);

  assign w_accept = start & ((r_state == S_IDLE) | (r_state == S_DONE));

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fprod_mag, w_fprod;
  assign w_fprod_mag = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
  assign w_fprod     = (w_a_neg ^ w_b_neg) ? -w_fprod_mag : w_fprod_mag;
  assign w_fast      = w_div0 | w_ovf | ~op[2];
`else
  assign w_fast      = w_div0 | w_ovf;
`endif

  // Single-cycle result for the fast-path cases.
  always_comb begin
    w_fast_res = '1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2])
      w_fast_res = (op[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
    else
`endif
    if (w_div0)
      w_fast_res = op[1] ? op1 : '1;
    else
      w_fast_res = op[1] ? '0 : op1;
  end

  // One iteration step. r_hi holds the partial product or the partial
  // remainder. r_lo holds the multiplier or the dividend shifting out,
  // with product or quotient bits shifting in.
  logic [XLEN:0]     w_msum, w_dsh, w_ddiff;
  logic              w_dge;
  logic [XLEN-1:0]   w_nhi, w_nlo;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_quot, w_remv, w_fin;

  assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_dsh   = {r_hi, r_lo[XLEN-1]};
  assign w_ddiff = w_dsh - {1'b0, r_b};
  assign w_dge   = ~w_ddiff[XLEN];

  assign w_nhi = r_is_div ? (w_dge ? w_ddiff[XLEN-1:0] : w_dsh[XLEN-1:0]) : w_msum[XLEN:1];
  assign w_nlo = r_is_div ? {r_lo[XLEN-2:0], w_dge} : {w_msum[0], r_lo[XLEN-1:1]};

  assign w_prod   = {w_nhi, w_nlo};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quot   = r_neg_q ? -w_nlo : w_nlo;
  assign w_remv   = r_neg_r ? -w_nhi : w_nhi;
  assign w_fin    = r_is_div ? (r_rem ? w_remv : w_quot)
                             : (r_mulh ? w_prod_s[2*XLEN-1:XLEN] : w_prod_s[XLEN-1:0]);

  // Sequencer: reset, flush, accept, iterate, and write the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_res    <= '0;
      r_is_div <= 1'b0;
      r_mulh   <= 1'b0;
      r_rem    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_is_div <= op[2];
            r_mulh   <= (op[1:0] != 2'b00);
            r_rem    <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_hi     <= '0;
            r_lo     <= w_a_mag;
            r_b      <= w_b_mag;
            if (w_fast) begin
              r_res   <= w_fast_res;
              r_state <= S_DONE;
            end else begin
              r_cnt   <= CW'(XLEN-1);
              r_state <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_hi <= w_nhi;
          r_lo <= w_nlo;
          if (r_cnt == '0) begin
            r_res   <= w_fin;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign res  = r_res;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): vector table, hand-written
// corner sequences, then random ops against a plain-arithmetic model.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;
  localparam logic [31:0] MINV = 32'h80000000;
  localparam int ITER_LAT = 33;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = ITER_LAT;
`endif

  logic clk = 1'b0;
  logic rst_n, start, flush;
  logic [2:0] op;
  logic [31:0] op1, op2;
  logic busy, done;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .op(op), .op1(op1), .op2(op2),
    .busy(busy), .done(done), .res(res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (o)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == MINV && b == 32'hFFFFFFFF) return a;
        p = sa / sb; return p[31:0];
      end
      OP_DIVU: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!o[0] && a == MINV && b == 32'hFFFFFFFF) return 1;
    return ITER_LAT;
  endfunction

  // Waits from a negedge for done, counting rising edges since the accept edge.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
  endtask

  // Called at a negedge with the unit IDLE or in DONE. Returns at the negedge where done is seen.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat, output bit busy_ok);
    start = 1'b1; op = o; op1 = a; op2 = b;
    @(posedge clk);
    lat = 1; busy_ok = 1'b1;
    #1;
    start = 1'b0; op = 3'($urandom); op1 = $urandom; op2 = $urandom;
    @(negedge clk);
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); lat++;
      @(negedge clk);
    end
    if (!busy) busy_ok = 1'b0;
    r = res;
  endtask

  vec_t vecs[$];
  logic [31:0] r, last_res, ra, rb;
  logic [2:0] ro;
  int lat, n, k;
  bit bok, saw;

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; op1 = '0; op2 = '0;

    vecs.push_back('{OP_MUL,    32'd7,        32'd6,        32'd42,       MUL_LAT});
    vecs.push_back('{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT});
    vecs.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT});
    vecs.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT});
    vecs.push_back('{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT});
    vecs.push_back('{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, ITER_LAT});
    vecs.push_back('{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, ITER_LAT});
    vecs.push_back('{OP_DIVU,   32'd100,      32'd7,        32'd14,       ITER_LAT});
    vecs.push_back('{OP_REMU,   32'd100,      32'd7,        32'd2,        ITER_LAT});
    vecs.push_back('{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, ITER_LAT});
    vecs.push_back('{OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        ITER_LAT});
    vecs.push_back('{OP_DIVU,   32'h1234,     32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{OP_REM,    32'h1234,     32'd0,        32'h1234,     1});
    vecs.push_back('{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_res", res, 32'd0);
    rst_n = 1'b1;

    // Flush while idle wins over start: nothing is accepted.
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = OP_DIVU; op1 = 32'd9; op2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("idle_flush_busy", {31'b0, busy}, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat, bok);
      check($sformatf("vec%0d_res", i), r, vecs[i].exp_res);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_busy", i), {31'b0, bok}, 32'd1);
    end

    // Start during CALC with a different op is ignored.
    start = 1'b1; op = OP_DIVU; op1 = 32'd100; op2 = 32'd7;
    @(posedge clk); n = 1; #1 start = 1'b0;
    repeat (5) begin @(posedge clk); n++; end
    #1 start = 1'b1; op = OP_MUL; op1 = 32'd3; op2 = 32'd3;
    @(posedge clk); n++; #1 start = 1'b0;
    @(negedge clk);
    wait_done(n, n);
    check("ignore_start_res", res, 32'd14);
    check("ignore_start_lat", n, ITER_LAT);

    // Back-to-back: start held high through DONE.
    start = 1'b1; op = OP_DIVU; op1 = 32'd100; op2 = 32'd7;
    @(posedge clk); #1 op = OP_REM; op1 = 32'hFFFFFFF9; op2 = 32'd2;
    @(negedge clk);
    wait_done(1, n);
    check("b2b_first_res", res, 32'd14);
    check("b2b_first_lat", n, ITER_LAT);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("b2b_second_accepted", {31'b0, busy & ~done}, 32'd1);
    wait_done(1, n);
    check("b2b_second_res", res, 32'hFFFFFFFF);
    check("b2b_second_lat", n, ITER_LAT);
    last_res = 32'hFFFFFFFF;

    // Flush at edge 10 after accept.
    start = 1'b1; op = OP_DIVU; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk);
    @(negedge clk); flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    saw = 1'b0;
    repeat (40) begin @(negedge clk); if (done) saw = 1'b1; end
    check("flush_no_done", {31'b0, saw}, 32'd0);
    check("flush_res_kept", res, last_res);

    // Reset at edge 10 after accept.
    start = 1'b1; op = OP_MULHU; op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_res", res, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Random ops against the arithmetic model.
    for (int t = 0; t < 200; t++) begin
      k  = $urandom_range(0, 7);
      ro = 3'($urandom_range(0, 7));
      ra = (k == 0) ? MINV : $urandom;
      case (k)
        1:       rb = 32'd0;
        2:       rb = 32'hFFFFFFFF;
        3:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      if (k == 4) ra = $urandom_range(0, 1000);
      run_op(ro, ra, rb, r, lat, bok);
      check($sformatf("rand%0d_res op=%0d a=%08h b=%08h", t, ro, ra, rb), r, ref_res(ro, ra, rb));
      check($sformatf("rand%0d_lat op=%0d", t, ro), lat, ref_lat(ro, ra, rb));
    end

    @(posedge clk);
    @(negedge clk);
    check("final_idle", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
